// File: rtl/mux_sel_pkg.sv
// Shared constants and state encoding for the mux select arbiter.
package mux_sel_pkg;

  localparam int unsigned NUM_CH = 4;
  localparam int unsigned CH_W   = 2;

  typedef enum logic {
    ST_IDLE,
    ST_GRANT
  } state_t;

endpackage

// File: rtl/mux_sel_arbiter_rr_pick.sv
// Combinational rotated priority encoder: first set request after 'last', wrapping.
module rr_pick
  import mux_sel_pkg::*;
(
  input  logic [NUM_CH-1:0] req,
  input  logic [CH_W-1:0]   last,
  output logic [CH_W-1:0]   pick,
  output logic              any
);

  logic [CH_W-1:0] w_idx;

  // Offset NUM_CH wraps back onto 'last', so the last holder has lowest priority.
  always_comb begin
    pick  = '0;
    any   = 1'b0;
    w_idx = '0;
    for (int unsigned k = 1; k <= NUM_CH; k++) begin
      w_idx = last + CH_W'(k);
      if (!any && req[w_idx]) begin
        any  = 1'b1;
        pick = w_idx;
      end
    end
  end

endmodule

// File: rtl/mux_sel_arbiter.sv
// Round-robin arbiter driving 4:1 mux selects; each grant is dwell-bounded and
// followed by a one-cycle bubble so the selects never move while valid is high.
module mux_sel_arbiter
  import mux_sel_pkg::*;
#(
  parameter int unsigned DWELL_W   = 4,
  parameter int unsigned MAX_DWELL = 8
) (
  input  logic               clk,
  input  logic               rst,
  input  logic [NUM_CH-1:0]  req,
  input  logic               done,
  output logic               s1,
  output logic               s0,
  output logic               valid,
  output logic [DWELL_W-1:0] dwell
);

  localparam logic [DWELL_W-1:0] DWELL_LAST = DWELL_W'(MAX_DWELL - 1);

  state_t             r_state;
  logic [CH_W-1:0]    r_sel;
  logic [CH_W-1:0]    r_last;
  logic               r_valid;
  logic [DWELL_W-1:0] r_dwell;

  logic [CH_W-1:0]    w_pick;
  logic               w_any;
  logic               w_release;

  rr_pick u_rr_pick (
    .req  (req),
    .last (r_last),
    .pick (w_pick),
    .any  (w_any)
  );

  assign w_release = done || !req[r_sel] || (r_dwell == DWELL_LAST);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state <= ST_IDLE;
      r_sel   <= '0;
      r_last  <= CH_W'(NUM_CH - 1);
      r_valid <= 1'b0;
      r_dwell <= '0;
    end else begin
      case (r_state)
        ST_IDLE: begin
          if (w_any) begin
            r_state <= ST_GRANT;
            r_sel   <= w_pick;
            r_last  <= w_pick;
            r_valid <= 1'b1;
            r_dwell <= '0;
          end
        end
        ST_GRANT: begin
          // Any combination of release causes collapses into one return to IDLE.
          if (w_release) begin
            r_state <= ST_IDLE;
            r_valid <= 1'b0;
            r_dwell <= '0;
          end else begin
            r_dwell <= r_dwell + DWELL_W'(1);
          end
        end
        default: begin
          r_state <= ST_IDLE;
          r_valid <= 1'b0;
          r_dwell <= '0;
        end
      endcase
    end
  end

  assign s1    = r_sel[1];
  assign s0    = r_sel[0];
  assign valid = r_valid;
  assign dwell = r_dwell;

  sel_stable_a: assert property (@(posedge clk) disable iff (rst)
    (valid && $past(valid)) |-> $stable({s1, s0}));

  dwell_bound_a: assert property (@(posedge clk) disable iff (rst)
    dwell <= DWELL_LAST);

endmodule

// File: tb/tb_mux_sel_arbiter.sv
// Scoreboard bench for mux_sel_arbiter: a behavioural model predicts outputs per edge.
module tb_mux_sel_arbiter;

  localparam int MAX_DWELL = 8;
  localparam int DWELL_W   = 4;

  logic               clk = 1'b0;
  logic               rst = 1'b0;
  logic [3:0]         req = '0;
  logic               done = 1'b0;
  logic               s1, s0, valid;
  logic [DWELL_W-1:0] dwell;

  mux_sel_arbiter #(
    .DWELL_W   (DWELL_W),
    .MAX_DWELL (MAX_DWELL)
  ) dut (
    .clk   (clk),
    .rst   (rst),
    .req   (req),
    .done  (done),
    .s1    (s1),
    .s0    (s0),
    .valid (valid),
    .dwell (dwell)
  );

  always #5 clk = ~clk;

  typedef struct {
    bit v;
    int ch;
    int dw;
  } exp_t;

  exp_t exp_q[$];
  int   dut_grants[$];
  int   n_tests = 0;
  int   n_fail  = 0;

  // Reference model: who holds the mux, for how long, and who went last.
  bit m_busy;
  int m_ch;
  int m_age;
  int m_last;

  function automatic void chk(string name, int act, int want);
    n_tests++;
    if (act != want) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, want, $time);
    end
  endfunction

  function automatic void model_reset();
    m_busy = 1'b0;
    m_ch   = 0;
    m_age  = 0;
    m_last = 3;
  endfunction

  function automatic void model_step(input logic [3:0] r, input logic d);
    if (m_busy) begin
      if (d || !r[m_ch] || m_age == MAX_DWELL - 1) begin
        m_busy = 1'b0;
        m_age  = 0;
      end else begin
        m_age++;
      end
    end else begin
      for (int k = 1; k <= 4; k++) begin
        int c;
        c = (m_last + k) % 4;
        if (!m_busy && r[c]) begin
          m_busy = 1'b1;
          m_ch   = c;
          m_last = c;
          m_age  = 0;
        end
      end
    end
  endfunction

  task automatic cyc(input logic [3:0] r, input logic d);
    exp_t e;
    req  = r;
    done = d;
    @(posedge clk);
    if (rst) model_reset();
    else     model_step(r, d);
    e.v  = m_busy;
    e.ch = m_ch;
    e.dw = m_busy ? m_age : 0;
    exp_q.push_back(e);
    #1;
  endtask

  task automatic assert_rst();
    rst = 1'b1;
    exp_q.delete();
    model_reset();
  endtask

  task automatic do_reset();
    assert_rst();
    cyc(4'b0000, 1'b0);
    cyc(4'b0000, 1'b0);
    rst = 1'b0;
  endtask

  bit mon_prev_v = 1'b0;
  always @(negedge clk) begin
    exp_t e;
    if (exp_q.size() > 0) begin
      e = exp_q.pop_front();
      chk("valid", int'(valid), int'(e.v));
      chk("sel",   int'({s1, s0}), e.ch);
      chk("dwell", int'(dwell), e.dw);
    end
    if (valid && !mon_prev_v) dut_grants.push_back(int'({s1, s0}));
    mon_prev_v = valid;
  end

  initial begin
    bit hit;
    model_reset();

    // Reset values
    #1;
    assert_rst();
    #1;
    chk("rst_valid", int'(valid), 0);
    chk("rst_sel",   int'({s1, s0}), 0);
    chk("rst_dwell", int'(dwell), 0);
    cyc(4'b0000, 1'b0);
    cyc(4'b0000, 1'b0);
    rst = 1'b0;

    // Single requester, dwell counting from 0
    cyc(4'b0000, 1'b0);
    for (int i = 0; i < 6; i++) cyc(4'b0001, 1'b0);
    for (int i = 0; i < 3; i++) cyc(4'b0000, 1'b1);

    // All requesting, random done: rotation 0,1,2,3,0 after reset
    do_reset();
    dut_grants.delete();
    for (int i = 0; i < 50; i++) cyc(4'b1111, 1'($urandom_range(0, 1)));
    chk("rr_enough_grants", int'(dut_grants.size() >= 5), 1);
    for (int i = 0; i < 5; i++)
      if (i < dut_grants.size()) chk("rr_order", dut_grants[i], i % 4);

    // Dwell limit: 8 valid cycles, 1 bubble, re-grant ch2
    do_reset();
    for (int i = 0; i < 30; i++) cyc(4'b0100, 1'b0);

    // After ch1, only ch3/ch1 alternate
    hit = 1'b0;
    for (int i = 0; i < 20 && !hit; i++) begin
      cyc(4'b0010, 1'b0);
      hit = m_busy && m_ch == 1;
    end
    chk("wait_ch1_grant", int'(hit), 1);
    for (int i = 0; i < 30; i++) cyc(4'b1010, 1'($urandom_range(0, 3) == 0));

    // Withdrawal mid-grant, then idle with no requests
    cyc(4'b0000, 1'b0);
    cyc(4'b0000, 1'b0);
    hit = 1'b0;
    for (int i = 0; i < 20 && !hit; i++) begin
      cyc(4'b0010, 1'b0);
      hit = m_busy && m_ch == 1;
    end
    chk("wait_ch1_again", int'(hit), 1);
    cyc(4'b0010, 1'b0);
    for (int i = 0; i < 5; i++) cyc(4'b0000, 1'b0);

    // Asynchronous reset during ch3 grant at dwell 5
    hit = 1'b0;
    for (int i = 0; i < 40 && !hit; i++) begin
      cyc(4'b1000, 1'b0);
      hit = m_busy && m_ch == 3 && m_age == 5;
    end
    chk("wait_ch3_dwell5", int'(hit), 1);
    #1;
    assert_rst();
    #1;
    chk("async_valid", int'(valid), 0);
    chk("async_sel",   int'({s1, s0}), 0);
    chk("async_dwell", int'(dwell), 0);
    cyc(4'b1000, 1'b0);
    cyc(4'b1000, 1'b0);
    rst = 1'b0;
    for (int i = 0; i < 4; i++) cyc(4'b1000, 1'b0);

    // Randomized traffic
    for (int i = 0; i < 400; i++) begin
      logic [3:0] r;
      r = req;
      if ($urandom_range(0, 3) == 0) r = 4'($urandom);
      cyc(r, 1'($urandom_range(0, 5) == 0));
    end

    cyc(4'b0000, 1'b0);
    @(negedge clk);
    #1;
    chk("scoreboard_drained", exp_q.size(), 0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

endmodule

// File: doc/mux_sel_arbiter.md
Name: mux_sel_arbiter

Overview:
- Upstream control stage for the 4-to-1 data multiplexer.
- Arbitrates among four per-input requests using a round-robin policy.
- Drives the mux select lines s1/s0 and a valid flag, so the downstream mux forwards exactly one granted data input at a time.
- Bounds each grant with a dwell counter and inserts a one-cycle bubble between grants, so select lines never change while valid is high.

Parameters:
- DWELL_W, 4, width of dwell counter.
- MAX_DWELL, 8, maximum cycles a grant may be held. Legal range is 1..2^DWELL_W.

Ports:
- clk  in  1  single clock, rising edge.
- rst  in  1  reset, asynchronous, active-high.
- req  in  4  req[i] requests mux data input di.
- done  in  1  consumer finished with the current channel; sampled only while valid=1.
- s1  out  1  mux select MSB.
- s0  out  1  mux select LSB.
- valid  out  1  select lines stable and grant active.
- dwell  out  DWELL_W  cycles elapsed in the current grant (debug/observe).

Behaviour:
- Reset (asynchronous, immediate on rst rise):
  - state=IDLE, s1=0, s0=0, valid=0, dwell=0.
  - last-granted pointer last=3, so first search starts at ch0.
- All outputs are registered. No combinational path from req or done to any output.
- Channel index ch = {s1,s0}. ch0..ch3 map to d0..d3.
- IDLE:
  - If req != 0, pick the first set req bit searching (last+1) mod 4, (last+2) mod 4, ... with wrap-around.
  - Next edge: state=GRANT, {s1,s0}=picked, valid=1, dwell=0, last=picked.
  - If req == 0: stay IDLE, valid=0, s1/s0 hold their previous value.
  - Latency: req asserted at edge N, valid=1 after edge N+1.
- GRANT:
  - Each edge without release: dwell = dwell+1.
  - Release conditions, any one sufficient:
    - (a) done=1
    - (b) req[ch]=0 (requester withdrew)
    - (c) dwell == MAX_DWELL-1
  - On release edge: state=IDLE, valid=0, dwell=0, s1/s0 held.
  - Simultaneous release conditions produce a single release. No extra state and no double bubble.
- Bubble: at least one cycle with valid=0 between consecutive grants, including re-granting the same channel.
- s1/s0 may change only on the edge where valid goes 0->1. Never while valid=1.
- Fairness:
  - With all four requests held, grants rotate 0,1,2,3,0,...
  - A continuously requesting channel is granted within 4 grants.
- MAX_DWELL=1: each grant lasts exactly one valid cycle.
- dwell never exceeds MAX_DWELL-1. Counter width DWELL_W, no overflow by construction.
- done while valid=0 is ignored.
- Reset mid-grant: valid drops to 0 and s1/s0 go to 00 asynchronously. Pointer returns to last=3.
- On the first edge after rst deasserts, normal IDLE arbitration resumes.

Decomposition:
- Shared package mux_sel_pkg:
  - constants NUM_CH=4, CH_W=2.
  - enum state_t {ST_IDLE, ST_GRANT}.
- One sub-module, rr_pick: combinational rotated priority encoder.
  - Inputs req[3:0] and last[1:0].
  - Outputs pick[1:0] and any.
- All registers (state, select, valid, dwell, last) live in mux_sel_arbiter.

Test Plan:
- Reset, then req=0001 at edge 2 -> valid=1, s1s0=00 after edge 3; dwell counts 0,1,2...
- req=1111 held; pulse done during each grant -> grant sequence ch0,ch1,ch2,ch3,ch0. Exactly one valid=0 cycle between each; s1s0 constant while valid=1.
- MAX_DWELL=8, req=0100 held, done=0 -> valid high exactly 8 cycles (dwell 0..7), low 1 cycle, then re-granted ch2. Pattern repeats.
- After a grant of ch1 (last=1), req=1010 -> next grant ch3, then ch1; ch0/ch2 never selected.
- Grant ch1, deassert req[1] mid-grant with done=0 -> valid=0 on the next edge, s1s0 stays 01. IDLE holds while req=0000.
- During grant of ch3 at dwell=5, assert rst between edges -> valid=0, s1s0=00, dwell=0 immediately without a clock edge. After release with req=1000 -> re-grant ch3 one edge later.
